mc_ctrl: RTL

- Multi-cycle control FSM for the MIPS core; sequences the shared ALU, PC, IR, register file and memory port across IF/ID/EX/MEM/WB.
- The single ALU is time-shared: PC+4 in FETCH, branch target in DECODE, operation or address in EXEC.
- Decodes opcode/funct into `alu_op` and datapath selects, and handles a req/ack memory handshake.

---
 rtl/mc_ctrl_pkg.sv | 86 ++++++++
 rtl/mc_ctrl_if.sv | 12 +
 rtl/mc_alu_dec.sv | 34 +++
 rtl/mc_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS controller: ALU codes, opcode/funct
// values, FSM state encoding, datapath select encodings and the decode-dispatch helper.
package mc_ctrl_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_OR    = 4'd2;
    localparam logic [3:0] ALU_LUI   = 4'd3;
    localparam logic [3:0] ALU_ADDIU = 4'd4;
    localparam logic [3:0] ALU_NOR   = 4'd5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_WB_ALU   = 4'd5;
    localparam logic [3:0] S_MEM_ADDR = 4'd6;
    localparam logic [3:0] S_MEM_RD   = 4'd7;
    localparam logic [3:0] S_MEM_WR   = 4'd8;
    localparam logic [3:0] S_WB_MEM   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_HALT     = 4'd12;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;
    localparam logic [1:0] SRCB_BR   = 2'd3;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_OUT    = 2'd1;
    localparam logic [1:0] PC_JMP    = 2'd2;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } ctrl_t;

    // Anything outside the supported subset lands in HALT.
    function automatic logic [3:0] decode_next(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] ns;
        ns = S_HALT;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_ADDU, FN_SUBU, FN_OR, FN_NOR: ns = S_EXEC_R;
                    default:                                 ns = S_HALT;
                endcase
            end
            OP_ADDIU, OP_ORI, OP_LUI: ns = S_EXEC_I;
            OP_LW, OP_SW:             ns = S_MEM_ADDR;
            OP_BEQ:                   ns = S_BRANCH;
            OP_J:                     ns = S_JUMP;
            default:                  ns = S_HALT;
        endcase
        return ns;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Memory request channel between the controller (master) and the memory port (slave).
interface mc_ctrl_if;
    // mem_req rises with mem_we stable and both stay put until the cycle mem_ack is high,
    // which completes the transfer; mem_ack while mem_req is low is ignored, and reset
    // may drop mem_req in the middle of a request.
    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (output mem_req, output mem_we, input mem_ack);
    modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/mc_alu_dec.sv
// Combinational opcode/funct to ALU operation decoder, consulted during the EXEC states.
module mc_alu_dec
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W   = 6,
    parameter int ALUOP_W = 4
) (
    input  logic [OPC_W-1:0]   opcode,
    input  logic [OPC_W-1:0]   funct,
    output logic [ALUOP_W-1:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                FN_SUBU:         alu_op = ALU_SUB;
                FN_OR:           alu_op = ALU_OR;
                FN_NOR:          alu_op = ALU_NOR;
                default:         alu_op = ALU_ADD;
            endcase
        end else begin
            // ori reuses the OR path; the ALU zero-extends the immediate itself.
            case (opcode)
                OP_ADDIU: alu_op = ALU_ADDIU;
                OP_ORI:   alu_op = ALU_OR;
                OP_LUI:   alu_op = ALU_LUI;
                default:  alu_op = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) driving a shared ALU, PC, IR and memory port.
// Optional CTRL_PERF_CNT_EN adds the retired-instruction and cycle counters.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W   = 6,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    mc_ctrl_if.master          mem,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [OPC_W-1:0]   funct,
    input  logic               alu_zero,
    output logic               iord,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_we,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               illegal,
    output logic [3:0]         dbg_state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]        retired,
    output logic [31:0]        cycles
`endif
);

    logic [3:0]         state;
    logic [3:0]         nxt;
    logic [ALUOP_W-1:0] dec_op;
    ctrl_t              c;

    mc_alu_dec #(
        .OPC_W   (OPC_W),
        .ALUOP_W (ALUOP_W)
    ) u_alu_dec (
        .opcode (opcode),
        .funct  (funct),
        .alu_op (dec_op)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        c        = '0;
        c.alu_op = ALU_ADD;
        nxt      = state;
        case (state)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                if (mem.mem_ack) begin
                    c.ir_we  = 1'b1;
                    c.pc_we  = 1'b1;
                    c.pc_src = PC_ALU;
                    nxt      = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively while the opcode is decoded.
                c.alu_src_b = SRCB_BR;
                nxt         = decode_next(opcode, funct);
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RT;
                c.alu_op    = dec_op;
                nxt         = S_WB_ALU;
            end
            S_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = dec_op;
                nxt         = S_WB_ALU;
            end
            S_WB_ALU: begin
                c.reg_we  = 1'b1;
                c.reg_dst = (opcode == OP_RTYPE);
                nxt       = S_FETCH;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                nxt         = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
                if (mem.mem_ack) nxt = S_WB_MEM;
            end
            S_MEM_WR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.iord    = 1'b1;
                if (mem.mem_ack) nxt = S_FETCH;
            end
            S_WB_MEM: begin
                c.reg_we     = 1'b1;
                c.mem_to_reg = 1'b1;
                nxt          = S_FETCH;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RT;
                c.alu_op    = ALU_SUB;
                c.pc_src    = PC_OUT;
                c.pc_we     = alu_zero;
                nxt         = S_FETCH;
            end
            S_JUMP: begin
                c.pc_we  = 1'b1;
                c.pc_src = PC_JMP;
                nxt      = S_FETCH;
            end
            S_HALT:  c.illegal = 1'b1;
            default: nxt = S_IDLE;
        endcase
    end

    assign mem.mem_req = c.mem_req;
    assign mem.mem_we  = c.mem_we;
    assign iord        = c.iord;
    assign ir_we       = c.ir_we;
    assign pc_we       = c.pc_we;
    assign pc_src      = c.pc_src;
    assign alu_src_a   = c.alu_src_a;
    assign alu_src_b   = c.alu_src_b;
    assign alu_op      = c.alu_op;
    assign reg_we      = c.reg_we;
    assign reg_dst     = c.reg_dst;
    assign mem_to_reg  = c.mem_to_reg;
    assign illegal     = c.illegal;
    assign dbg_state   = state;

`ifdef CTRL_PERF_CNT_EN
    logic retire;

    always_comb begin
        retire = 1'b0;
        if (nxt == S_FETCH) begin
            retire = (state == S_WB_ALU) || (state == S_WB_MEM) || (state == S_MEM_WR) ||
                     (state == S_BRANCH) || (state == S_JUMP);
        end
    end

    // Counted on entry, so the visible cycles value includes the cycle now in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
            cycles  <= '0;
        end else begin
            if (nxt != S_IDLE) cycles  <= cycles + 32'd1;
            if (retire)        retired <= retired + 32'd1;
        end
    end
`endif

endmodule
